// File: rtl/snow64_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps one cache request in flight
// and feeds a stall-aware decode holding register. Redirects from EX flush stale fetches.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   out_req_valid/addr fetch request to the instruction cache
//   in_req_ready       cache accepts the request this cycle
//   in_rsp_valid/instr returned instruction word (one-cycle pulse)
//   in_redirect_*      branch/jump target from EX
//   in_stall           hold the decode register
//   out_instr_valid    decode register holds an instruction
//   out_instr/_pc      instruction and its PC to the decoder
module snow64_fetch_ctrl #(
  parameter int ADDR_WIDTH = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int INSTR_BYTES = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   out_req_valid,
  output logic [ADDR_WIDTH-1:0]  out_req_addr,
  input  logic                   in_req_ready,
  input  logic                   in_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] in_rsp_instr,
  input  logic                   in_redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  in_redirect_addr,
  input  logic                   in_stall,
  output logic                   out_instr_valid,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]  out_instr_pc
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_WIDTH-1:0] pc;
  logic slot_free;
  logic load;

  assign slot_free = !out_instr_valid || !in_stall;

  // A response is only kept when it belongs to the current PC
  // and no redirect arrives in the same cycle.
  assign load = (state == S_WAIT) && in_rsp_valid
              && !in_redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_REQ: begin
        if (out_req_valid && in_req_ready)
          state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (in_rsp_valid)
          state_nx = S_REQ;
        else if (in_redirect_valid)
          state_nx = S_DROP;
      end
      S_DROP: begin
        if (in_rsp_valid)
          state_nx = S_REQ;
      end
      default: state_nx = S_REQ;
    endcase
  end

  always_comb begin
    out_req_valid = 1'b0;
    out_req_addr  = pc;
    if (state == S_REQ)
      out_req_valid = slot_free && !in_redirect_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc              <= RESET_PC;
      out_instr_valid <= 1'b0;
      out_instr       <= '0;
      out_instr_pc    <= '0;
    end else if (in_redirect_valid) begin
      // Flush wins over stall: the held instruction is on the wrong path.
      pc              <= in_redirect_addr;
      out_instr_valid <= 1'b0;
    end else if (load) begin
      out_instr       <= in_rsp_instr;
      out_instr_pc    <= pc;
      out_instr_valid <= 1'b1;
      pc              <= pc + ADDR_WIDTH'(INSTR_BYTES);
    end else if (out_instr_valid && !in_stall) begin
      out_instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snow64_fetch_ctrl.sv
// Testbench for snow64_fetch_ctrl: directed scenarios plus a randomized
// run against a transaction-level model of the fetch rules.
module tb_snow64_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic        redir_valid;
  logic [63:0] redir_addr;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  snow64_fetch_ctrl dut (
    .clk(clk),
    .rst(rst),
    .out_req_valid(req_valid),
    .out_req_addr(req_addr),
    .in_req_ready(req_ready),
    .in_rsp_valid(rsp_valid),
    .in_rsp_instr(rsp_instr),
    .in_redirect_valid(redir_valid),
    .in_redirect_addr(redir_addr),
    .in_stall(stall),
    .out_instr_valid(instr_valid),
    .out_instr(instr),
    .out_instr_pc(instr_pc)
  );

  function automatic logic [31:0] w(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  // Drive one cycle of inputs after the falling edge; outputs
  // are then observed 1ns later, well away from the rising edge.
  task automatic set_in(input logic r, input logic rdy,
                        input logic rv, input logic [31:0] ri,
                        input logic dv, input logic [63:0] da,
                        input logic st);
    @(negedge clk);
    rst = r;
    req_ready = rdy;
    rsp_valid = rv;
    rsp_instr = ri;
    redir_valid = dv;
    redir_addr = da;
    stall = st;
    #1;
  endtask

  task automatic idle(input logic rdy, input logic st);
    set_in(1'b0, rdy, 1'b0, '0, 1'b0, '0, st);
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    set_in(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_fetch(input logic [63:0] a);
    idle(1'b1, 1'b0);
    set_in(1'b0, 1'b0, 1'b1, w(a), 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 64'h0) begin
      failures++;
      $display("FAIL reset_state: valid=%b instr=%h pc=%h want 0/0/0",
               instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_free_run();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle(1'b1, 1'b0);
      checks++;
      if (req_valid !== 1'b1 || req_addr !== 64'(4 * k)) begin
        failures++;
        $display("FAIL free_run_req%0d: valid=%b addr=%h want 1/%h",
                 k, req_valid, req_addr, 64'(4 * k));
      end
      if (k == 0) begin
        checks++;
        if (instr_valid !== 1'b0) begin
          failures++;
          $display("FAIL free_run_valid_after_reset: got %b want 0", instr_valid);
        end
      end else begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 64'(4 * (k - 1))
            || instr !== w(64'(4 * (k - 1)))) begin
          failures++;
          $display("FAIL free_run_out%0d: v=%b pc=%h instr=%h want 1/%h/%h",
                   k, instr_valid, instr_pc, instr,
                   64'(4 * (k - 1)), w(64'(4 * (k - 1))));
        end
      end
      set_in(1'b0, 1'b0, 1'b1, w(64'(4 * k)), 1'b0, '0, 1'b0);
    end
    idle(1'b0, 1'b0);
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 64'h8 || instr !== w(64'h8)) begin
      failures++;
      $display("FAIL free_run_out_last: v=%b pc=%h instr=%h want 1/8/%h",
               instr_valid, instr_pc, instr, w(64'h8));
    end
  endtask

  task automatic test_stall();
    do_reset();
    do_fetch(64'h0);
    do_fetch(64'h4);
    for (int k = 0; k < 3; k++) begin
      idle(1'b1, 1'b1);
      checks++;
      if (req_valid !== 1'b0 || instr_valid !== 1'b1
          || instr_pc !== 64'h4 || instr !== w(64'h4)) begin
        failures++;
        $display("FAIL stall_hold%0d: req=%b v=%b pc=%h instr=%h want 0/1/4/%h",
                 k, req_valid, instr_valid, instr_pc, instr, w(64'h4));
      end
    end
    idle(1'b1, 1'b0);
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 64'h8) begin
      failures++;
      $display("FAIL stall_release: req=%b addr=%h want 1/8", req_valid, req_addr);
    end
    set_in(1'b0, 1'b0, 1'b1, w(64'h8), 1'b0, '0, 1'b0);
    idle(1'b0, 1'b0);
  endtask

  task automatic test_redirect_wait();
    do_reset();
    idle(1'b1, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, 64'h1000, 1'b0);
    checks++;
    if (req_valid !== 1'b0) begin
      failures++;
      $display("FAIL redir_wait_req: got %b want 0", req_valid);
    end
    idle(1'b1, 1'b0);
    set_in(1'b0, 1'b1, 1'b1, w(64'h0), 1'b0, '0, 1'b0);
    checks++;
    if (req_valid !== 1'b0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL redir_wait_drop: req=%b v=%b want 0/0", req_valid, instr_valid);
    end
    idle(1'b1, 1'b0);
    checks++;
    if (instr_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 64'h1000) begin
      failures++;
      $display("FAIL redir_wait_next: v=%b req=%b addr=%h want 0/1/1000",
               instr_valid, req_valid, req_addr);
    end
    set_in(1'b0, 1'b0, 1'b1, w(64'h1000), 1'b0, '0, 1'b0);
    idle(1'b0, 1'b0);
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 64'h1000 || instr !== w(64'h1000)) begin
      failures++;
      $display("FAIL redir_wait_out: v=%b pc=%h instr=%h want 1/1000/%h",
               instr_valid, instr_pc, instr, w(64'h1000));
    end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    idle(1'b1, 1'b0);
    set_in(1'b0, 1'b0, 1'b1, w(64'h0), 1'b1, 64'h2000, 1'b0);
    idle(1'b0, 1'b0);
    checks++;
    if (instr_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 64'h2000) begin
      failures++;
      $display("FAIL redir_same: v=%b req=%b addr=%h want 0/1/2000",
               instr_valid, req_valid, req_addr);
    end
  endtask

  task automatic test_redirect_stalled();
    do_reset();
    do_fetch(64'h0);
    idle(1'b0, 1'b1);
    checks++;
    if (instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL redir_stall_pre: v=%b want 1", instr_valid);
    end
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, 64'h3000, 1'b1);
    idle(1'b0, 1'b1);
    checks++;
    if (instr_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 64'h3000) begin
      failures++;
      $display("FAIL redir_stall_flush: v=%b req=%b addr=%h want 0/1/3000",
               instr_valid, req_valid, req_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    do_fetch(64'hFFFF_FFFF_FFFF_FFFC);
    idle(1'b0, 1'b0);
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 64'hFFFF_FFFF_FFFF_FFFC
        || req_addr !== 64'h0) begin
      failures++;
      $display("FAIL wrap: v=%b pc=%h addr=%h want 1/fffffffffffffffc/0",
               instr_valid, instr_pc, req_addr);
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    idle(1'b1, 1'b0);
    set_in(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    set_in(1'b0, 1'b0, 1'b1, w(64'h0), 1'b0, '0, 1'b0);
    checks++;
    if (instr_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 64'h0) begin
      failures++;
      $display("FAIL rst_wait_state: v=%b req=%b addr=%h want 0/1/0",
               instr_valid, req_valid, req_addr);
    end
    idle(1'b0, 1'b0);
    checks++;
    if (instr_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 64'h0) begin
      failures++;
      $display("FAIL rst_wait_late_rsp: v=%b req=%b addr=%h want 0/1/0",
               instr_valid, req_valid, req_addr);
    end
  endtask

  // Model: a fetch is either absent, in flight for the current PC,
  // or in flight but stale (a redirect arrived after issue).
  task automatic test_random();
    logic [63:0] m_pc = '0;
    logic [63:0] m_ipc = '0;
    logic [31:0] m_instr = '0;
    logic m_valid = 1'b0;
    bit pending = 0;
    bit stale = 0;
    int cnt = 0;
    logic [63:0] caddr = '0;
    logic rv, dv, st, rdy, exp_req, fire;
    logic [31:0] ri;
    logic [63:0] da;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rv = 1'b0;
      ri = '0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          rv = 1'b1;
          ri = w(caddr);
        end
      end
      st = ($urandom_range(0, 9) < 3);
      dv = ($urandom_range(0, 19) == 0);
      da = ($urandom_range(0, 9) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
           : {32'($urandom), 32'($urandom)} & ~64'h3;
      rdy = ($urandom_range(0, 9) < 7);
      set_in(1'b0, rdy, rv, ri, dv, da, st);
      exp_req = !pending && (!m_valid || !st) && !dv;
      checks++;
      if (req_valid !== exp_req || (exp_req && req_addr !== m_pc)) begin
        failures++;
        $display("FAIL rand_req@%0d: v=%b addr=%h want %b/%h",
                 n, req_valid, req_addr, exp_req, m_pc);
      end
      checks++;
      if (instr_valid !== m_valid
          || (m_valid && (instr !== m_instr || instr_pc !== m_ipc))) begin
        failures++;
        $display("FAIL rand_out@%0d: v=%b instr=%h pc=%h want %b/%h/%h",
                 n, instr_valid, instr, instr_pc, m_valid, m_instr, m_ipc);
      end
      fire = exp_req && rdy;
      if (fire) begin
        cnt = $urandom_range(1, 3);
        caddr = m_pc;
      end
      if (dv) begin
        m_pc = da;
        m_valid = 1'b0;
        if (pending && rv) begin
          pending = 0;
          stale = 0;
        end else if (pending) begin
          stale = 1;
        end
      end else begin
        if (pending && rv && !stale) begin
          m_instr = ri;
          m_ipc = m_pc;
          m_valid = 1'b1;
          m_pc = m_pc + 64'd4;
        end else if (m_valid && !st) begin
          m_valid = 1'b0;
        end
        if (pending && rv) begin
          pending = 0;
          stale = 0;
        end
      end
      if (fire) pending = 1;
    end
    while (cnt > 0) begin
      cnt--;
      set_in(1'b0, 1'b0, cnt == 0, w(caddr), 1'b0, '0, 1'b0);
    end
    idle(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_instr = '0;
    redir_valid = 1'b0;
    redir_addr = '0;
    stall = 1'b0;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_redirect_stalled();
    test_wrap();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snow64_fetch_ctrl.md
Name: snow64_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the IF/ID stage.
- Owns the fetch PC and issues single-outstanding requests to the instruction cache.
- Presents each returned instruction and its PC to the decoder through a holding register that obeys the control unit's stall.
- Applies branch/redirect requests from EX, discarding any in-flight fetch that the redirect makes stale.

Parameters:
ADDR_WIDTH, 64, width of PC and cache request address
INSTR_WIDTH, 32, width of one instruction word
INSTR_BYTES, 4, PC increment per sequential fetch
RESET_PC, 0, PC value loaded by reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
out_req_valid  out  1  fetch request to instr cache
out_req_addr  out  ADDR_WIDTH  fetch address (current PC)
in_req_ready  in  1  cache accepts request this cycle
in_rsp_valid  in  1  cache returns instruction (one cycle pulse)
in_rsp_instr  in  INSTR_WIDTH  returned instruction word
in_redirect_valid  in  1  redirect from EX (branch taken / jump)
in_redirect_addr  in  ADDR_WIDTH  redirect target
in_stall  in  1  control unit: hold current decode output
out_instr_valid  out  1  decode register holds a valid instruction
out_instr  out  INSTR_WIDTH  instruction to decoder
out_instr_pc  out  ADDR_WIDTH  PC of out_instr

Behaviour:
- Reset (rst=1 at edge): state=REQ; pc=RESET_PC; out_instr_valid=0; out_instr=0; out_instr_pc=0. rst overrides every other input. Mid-operation reset abandons any outstanding fetch; a late in_rsp_valid arriving while in REQ is ignored.
- States: REQ, WAIT, DROP.
- slot_free = !out_instr_valid || !in_stall. A valid instruction is consumed on any cycle where out_instr_valid=1 and in_stall=0.
- Consumption clears out_instr_valid next cycle unless a new instruction loads in the same edge.
- REQ:
  - out_req_valid = slot_free && !in_redirect_valid; out_req_addr = pc (combinational from the pc register).
  - out_req_valid && in_req_ready -> WAIT.
- WAIT:
  - out_req_valid=0.
  - On in_rsp_valid: out_instr<=in_rsp_instr, out_instr_pc<=pc, out_instr_valid<=1, pc<=pc+INSTR_BYTES (mod 2^ADDR_WIDTH, wraps silently), -> REQ.
  - The slot is guaranteed free at response time because issue required slot_free.
- DROP:
  - out_req_valid=0.
  - Waits for the stale response; on in_rsp_valid the response is discarded, -> REQ.
- Redirect (in_redirect_valid=1) has highest priority after rst:
  - pc<=in_redirect_addr; out_instr_valid<=0 (flush, even if stalled).
  - In REQ: request suppressed that cycle; stay REQ.
  - In WAIT: if in_rsp_valid is asserted the same cycle, discard it and go -> REQ; else -> DROP.
  - In DROP: pc updated, stay DROP (newest redirect wins).
- Simultaneous redirect and rsp in DROP: rsp discarded, pc<=redirect addr, -> REQ.
- Latency: request accept to out_instr_valid = cache latency + 1 cycle. Throughput ≤ 1 instr / 2 cycles with a 1-cycle cache.
- in_rsp_valid in REQ (protocol violation) is ignored.
- Never more than one outstanding request.

Test Plan:
- Reset then free-run, 1-cycle cache, in_stall=0 -> request addrs 0x0, 0x4, 0x8; out_instr_pc follows 0x0, 0x4, 0x8 with matching instr words; out_instr_valid=0 during and one cycle after reset.
- in_stall=1 while out_instr_valid=1 (pc 0x4) for 3 cycles -> out_instr/out_instr_pc held constant; out_req_valid=0 throughout; next request (0x8) issues on the cycle in_stall drops.
- Redirect to 0x1000 while in WAIT, response arrives 2 cycles later -> that response discarded (never valid on out); next request addr 0x1000; out_instr_pc=0x1000.
- Redirect to 0x2000 on the same cycle as in_rsp_valid in WAIT -> instruction dropped; out_instr_valid=0 next cycle; next request addr 0x2000.
- Redirect while stalled with out_instr_valid=1 -> out_instr_valid=0 next cycle despite in_stall=1.
- pc=0xFFFF_FFFF_FFFF_FFFC fetch completes -> next request addr 0x0. Separately, assert rst while in WAIT -> state REQ, pc=RESET_PC, late in_rsp_valid ignored.
